// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encodings, default word width
// and the bit-counter width helper.
package word_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Parallel word input and serial bit output of the word serializer.
// Handshake: a word transfers at a rising clk edge where in_valid and in_ready are both 1.
interface word_serializer_if
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_bit;
    logic             ser_valid;
    logic             busy;
    logic             word_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_bit, ser_valid, busy, word_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_bit, ser_valid, busy, word_done
    );
endinterface

// File: rtl/word_serializer_hold_buf.sv
// One-entry holding register. A write always wins over a same-edge read, so a word can be
// taken and replaced in the same cycle while the buffer stays full.
module word_serializer_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (wr_en) begin
            full <= 1'b1;
            data <= wr_data;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, one registered bit per clock out.
// Define WORD_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    word_serializer_if.slave    bus,
    output logic [1:0]          state_dbg
);

    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             ser_bit_q;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             par_q;
`endif

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             accept;
    logic             last_bit;
    logic             shift_free;
    logic             load;
    logic             hold_wr;
    logic             hold_rd;
    logic [WIDTH-1:0] ld_word;

    assign accept = bus.in_valid & ~hold_full;

`ifdef WORD_SERIALIZER_PARITY_EN
    assign last_bit = (state == ST_PARITY);
`else
    assign last_bit = (state == ST_SHIFT) && (cnt == LAST);
`endif

    // The shifter can take a new word at this edge if it is idle or emitting its final bit.
    assign shift_free = (state == ST_IDLE) | last_bit;
    assign load       = shift_free & (hold_full | accept);
    assign ld_word    = hold_full ? hold_data : bus.in_data;
    assign hold_rd    = shift_free & hold_full;
    assign hold_wr    = accept & (hold_full | ~shift_free);

    word_serializer_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (hold_wr),
        .wr_data (bus.in_data),
        .rd_en   (hold_rd),
        .full    (hold_full),
        .data    (hold_data)
    );

    // sreg holds the bits not yet shown; ser_bit_q is the bit on the wire this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sreg      <= '0;
            ser_bit_q <= IDLE_BIT;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (load) begin
            state <= ST_SHIFT;
            cnt   <= '0;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q <= ^ld_word;
`endif
            if (MSB_FIRST) begin
                ser_bit_q <= ld_word[WIDTH-1];
                sreg      <= {ld_word[WIDTH-2:0], 1'b0};
            end else begin
                ser_bit_q <= ld_word[0];
                sreg      <= {1'b0, ld_word[WIDTH-1:1]};
            end
        end else if (last_bit) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ser_bit_q <= IDLE_BIT;
`ifdef WORD_SERIALIZER_PARITY_EN
        end else if ((state == ST_SHIFT) && (cnt == LAST)) begin
            state     <= ST_PARITY;
            ser_bit_q <= par_q;
`endif
        end else if (state == ST_SHIFT) begin
            cnt <= cnt + 1'b1;
            if (MSB_FIRST) begin
                ser_bit_q <= sreg[WIDTH-1];
                sreg      <= {sreg[WIDTH-2:0], 1'b0};
            end else begin
                ser_bit_q <= sreg[0];
                sreg      <= {1'b0, sreg[WIDTH-1:1]};
            end
        end
    end

    assign bus.in_ready  = ~hold_full;
    assign bus.ser_bit   = ser_bit_q;
    assign bus.ser_valid = (state != ST_IDLE);
    assign bus.word_done = last_bit;
    assign bus.busy      = (state != ST_IDLE) | hold_full;
    assign state_dbg     = state;

endmodule
